maxpool_layer: RTL

MAXPOOL_LAYER -- requirements
Module: maxpool_layer

---
 rtl/cnn_pkg.sv | 17 +
 rtl/maxpool_buf.sv | 36 +++
 rtl/maxpool_layer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and helpers for the CNN pipeline blocks
// Purpose: pooling state enum and counter-width helper shared by maxpool_layer
//          and maxpool_buf.
// Contents: pool_state_t (ACCUM, EMIT), cnt_width(n).
package cnn_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } pool_state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool_buf.sv
// rtl/maxpool_buf.sv - per-channel running-max storage for maxpool_layer
// Purpose: INPUT_SIZE x WORD_SIZE register array, one write port and one
//          combinational read port sharing the same channel index.
// Ports:
//   clk_i  - clock, writes on rising edge
//   we     - write enable
//   addr   - channel index for both read and write
//   wdata  - word written at addr when we is high
//   rdata  - word currently stored at addr (combinational)
module maxpool_buf
  import cnn_pkg::*;
#(
  parameter int INPUT_SIZE = 2,
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_W     = cnt_width(INPUT_SIZE)
) (
  input  logic                        clk_i,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           addr,
  input  logic signed [WORD_SIZE-1:0] wdata,
  output logic signed [WORD_SIZE-1:0] rdata
);

  logic signed [WORD_SIZE-1:0] mem [INPUT_SIZE];

  // Contents are meaningless until the first frame of a window overwrites
  // them, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/maxpool_layer.sv
// rtl/maxpool_layer.sv - streaming max-pool over POOL_SIZE consecutive frames
// Purpose: takes INPUT_SIZE-channel frames one word per beat and emits, per
//          channel, the signed maximum over each window of POOL_SIZE frames.
// Optional feature: define MAXPOOL_RELU_EN to clamp negative pooled results
//          to zero before they are registered out.
// Ports:
//   clk_i    - clock
//   reset_i  - asynchronous active-high reset
//   valid_i  - upstream word valid
//   ready_o  - block accepts data_r_i this cycle
//   data_r_i - incoming signed word
//   valid_o  - data_r_o holds a pooled word
//   ready_i  - downstream accepts data_r_o
//   data_r_o - pooled signed word, channel order preserved
module maxpool_layer
  import cnn_pkg::*;
#(
  parameter int INPUT_SIZE = 2,
  parameter int WORD_SIZE  = 8,
  parameter int POOL_SIZE  = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [WORD_SIZE-1:0] data_r_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic signed [WORD_SIZE-1:0] data_r_o
);

  localparam int CW = cnt_width(INPUT_SIZE);
  localparam int FW = cnt_width(POOL_SIZE);
  localparam logic [CW-1:0] CH_LAST = CW'(INPUT_SIZE - 1);
  localparam logic [FW-1:0] FR_LAST = FW'(POOL_SIZE - 1);
  // With a single-frame window every word is the last frame of its window.
  localparam pool_state_t START_STATE = (POOL_SIZE == 1) ? EMIT : ACCUM;

  logic [CW-1:0]               ch;
  logic [FW-1:0]               fr;
  logic [FW-1:0]               fr_inc;
  pool_state_t                 state;

  logic                        in_fire;
  logic                        out_fire;
  logic                        buf_we;
  logic signed [WORD_SIZE-1:0] stored;
  logic signed [WORD_SIZE-1:0] max_val;
  logic signed [WORD_SIZE-1:0] pooled;
  logic signed [WORD_SIZE-1:0] result;
  logic signed [WORD_SIZE-1:0] buf_wdata;

  // ACCUM only updates the buffer, so it never stalls; EMIT needs the output
  // register free or draining this cycle.
  assign ready_o  = (state == ACCUM) || !valid_o || ready_i;
  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

  // Strict greater-than so a tie keeps the stored value.
  assign max_val = (data_r_i > stored) ? data_r_i : stored;
  assign pooled  = (POOL_SIZE == 1) ? data_r_i : max_val;

`ifdef MAXPOOL_RELU_EN
  assign result = pooled[WORD_SIZE-1] ? '0 : pooled;
`else
  assign result = pooled;
`endif

  // Frame 0 seeds the buffer; later ACCUM frames fold into it.
  assign buf_we    = in_fire && (state == ACCUM);
  assign buf_wdata = (fr == '0) ? data_r_i : max_val;
  assign fr_inc    = fr + FW'(1);

  maxpool_buf #(
    .INPUT_SIZE (INPUT_SIZE),
    .WORD_SIZE  (WORD_SIZE),
    .ADDR_W     (CW)
  ) u_buf (
    .clk_i (clk_i),
    .we    (buf_we),
    .addr  (ch),
    .wdata (buf_wdata),
    .rdata (stored)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ch       <= '0;
      fr       <= '0;
      state    <= START_STATE;
      valid_o  <= 1'b0;
      data_r_o <= '0;
    end else begin
      if (in_fire) begin
        if (ch == CH_LAST) begin
          ch <= '0;
          if (fr == FR_LAST) begin
            fr    <= '0;
            state <= START_STATE;
          end else begin
            fr    <= fr_inc;
            state <= (fr_inc == FR_LAST) ? EMIT : ACCUM;
          end
        end else begin
          ch <= ch + CW'(1);
        end
      end

      // A new EMIT word replaces a draining one in the same cycle, which
      // keeps the output at one word per cycle.
      if (in_fire && (state == EMIT)) begin
        data_r_o <= result;
        valid_o  <= 1'b1;
      end else if (out_fire) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
